// File: rtl/mmio_input_ctrl.sv
// Memory-mapped KEY/SW responder on the M-stage data bus: synchronizes pins, debounces SW,
// keeps sticky ready/overrun status with per-device interrupt enables and drives irq.
module mmio_input_ctrl #(
  parameter int                 DBITS     = 32,
  parameter logic [DBITS-1:0]   KEYBASE   = 32'hFFFFF080,
  parameter logic [DBITS-1:0]   SWBASE    = 32'hFFFFF090,
  parameter int                 DEBBITS   = 20,
  parameter logic [DEBBITS-1:0] DEBCYCLES = 20'd500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] bus_addr,
  input  logic [DBITS-1:0] bus_wrdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic             bus_sel,
  output logic [DBITS-1:0] bus_rddata,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic             irq
);
  localparam logic [DBITS-1:0]   KDATA_A  = KEYBASE;
  localparam logic [DBITS-1:0]   KCTRL_A  = KEYBASE + DBITS'(4);
  localparam logic [DBITS-1:0]   SDATA_A  = SWBASE;
  localparam logic [DBITS-1:0]   SCTRL_A  = SWBASE + DBITS'(4);
  localparam logic [DEBBITS-1:0] DEB_LAST = DEBCYCLES - DEBBITS'(1);

  logic [3:0]         key_meta, key_state;
  logic [9:0]         sw_meta, sw_samp, sw_state;
  logic [DEBBITS-1:0] deb_cnt;
  logic [2:0]         kstat, sstat;  // {ie, ovr, ready}

  logic kchg, schg, sw_moving;
  logic krd_clr, srd_clr, kwr, swr;

  assign kchg      = (key_meta != key_state);
  assign sw_moving = (sw_meta != sw_samp);
  assign schg      = (sw_samp != sw_state) && (deb_cnt == DEB_LAST);

  assign krd_clr = bus_re && (bus_addr == KDATA_A);
  assign srd_clr = bus_re && (bus_addr == SDATA_A);
  assign kwr     = bus_we && (bus_addr == KCTRL_A);
  assign swr     = bus_we && (bus_addr == SCTRL_A);

  // A new event always wins over any clear in the same cycle; only a read-clear
  // racing the event suppresses overrun, since that read consumed the prior event.
  function automatic logic [2:0] stat_next(input logic [2:0] cur, input logic chg,
                                           input logic rd_clr, input logic wr,
                                           input logic [DBITS-1:0] wd);
    logic ie, ovr, rdy;
    ie  = wr ? wd[4] : cur[2];
    ovr = cur[1];
    if (chg && cur[0] && !rd_clr) ovr = 1'b1;
    else if (wr && !wd[2])        ovr = 1'b0;
    rdy = cur[0];
    if (chg)                            rdy = 1'b1;
    else if (rd_clr || (wr && !wd[0])) rdy = 1'b0;
    return {ie, ovr, rdy};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta  <= '0;
      key_state <= '0;
      sw_meta   <= '0;
      sw_samp   <= '0;
      sw_state  <= '0;
      deb_cnt   <= '0;
      kstat     <= '0;
      sstat     <= '0;
      irq       <= 1'b0;
    end else begin
      key_meta  <= ~KEY;
      key_state <= key_meta;
      sw_meta   <= SW;
      sw_samp   <= sw_meta;
      // Sample about to change restarts the stability window.
      if (schg) begin
        sw_state <= sw_samp;
        deb_cnt  <= '0;
      end else if (sw_moving || (sw_samp == sw_state)) begin
        deb_cnt  <= '0;
      end else begin
        deb_cnt  <= deb_cnt + DEBBITS'(1);
      end
      kstat <= stat_next(kstat, kchg, krd_clr, kwr, bus_wrdata);
      sstat <= stat_next(sstat, schg, srd_clr, swr, bus_wrdata);
      irq   <= (kstat[0] & kstat[2]) | (sstat[0] & sstat[2]);
    end
  end

  always_comb begin
    bus_sel    = 1'b1;
    bus_rddata = '0;
    case (bus_addr)
      KDATA_A: bus_rddata = DBITS'(key_state);
      KCTRL_A: bus_rddata = DBITS'({kstat[2], 1'b0, kstat[1], 1'b0, kstat[0]});
      SDATA_A: bus_rddata = DBITS'(sw_state);
      SCTRL_A: bus_rddata = DBITS'({sstat[2], 1'b0, sstat[1], 1'b0, sstat[0]});
      default: bus_sel    = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_mmio_input_ctrl.sv
// Directed bench for mmio_input_ctrl with a short debounce window (DEBCYCLES=1000).
module tb_mmio_input_ctrl;
  localparam logic [31:0] KDATA = 32'hFFFFF080;
  localparam logic [31:0] KCTRL = 32'hFFFFF084;
  localparam logic [31:0] SDATA = 32'hFFFFF090;
  localparam logic [31:0] SCTRL = 32'hFFFFF094;
  localparam int          DEB   = 1000;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] bus_addr = '0, bus_wrdata = '0, bus_rddata;
  logic        bus_we = 1'b0, bus_re = 1'b0, bus_sel, irq;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  int          errs = 0, checks = 0;

  mmio_input_ctrl #(.DEBCYCLES(20'd1000)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_sel(bus_sel), .bus_rddata(bus_rddata),
    .KEY(KEY), .SW(SW), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_addr = a;
    #1 chk(tag, bus_rddata, exp);
  endtask

  task automatic lw(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_addr = a; bus_re = 1'b1;
    #1 chk(tag, bus_rddata, exp);
    cyc(1);
    bus_re = 1'b0;
  endtask

  task automatic sw_op(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wrdata = d; bus_we = 1'b1;
    cyc(1);
    bus_we = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    peek("rst_kctrl", KCTRL, 32'd0);
    peek("rst_sdata", SDATA, 32'd0);
    reset = 1'b0;
    cyc(1);

    // KEY0 pressed: two-cycle sync, then ready; LW clears ready.
    KEY = 4'b1110;
    cyc(1);
    peek("key_lat1", KDATA, 32'd0);
    cyc(1);
    peek("key_data", KDATA, 32'd1);
    chk("key_sel", {31'b0, bus_sel}, 32'd1);
    peek("key_ready", KCTRL, 32'd1);
    lw("key_lw", KDATA, 32'd1);
    peek("key_rdclr", KCTRL, 32'd0);

    // Two events without a read -> overrun; store 0 clears, store 1 cannot set.
    KEY = 4'b1100; cyc(3);
    peek("ovr_first", KCTRL, 32'd1);
    KEY = 4'b1000; cyc(3);
    peek("ovr_second", KCTRL, 32'd5);
    peek("ovr_kdata", KDATA, 32'd7);
    sw_op(KCTRL, 32'd0);
    peek("ctrl_clr", KCTRL, 32'd0);
    sw_op(KCTRL, 32'd1);
    peek("ctrl_set1", KCTRL, 32'd0);

    // Event lands on the same edge as LW KDATA while ready.
    KEY = 4'b1001; cyc(3);
    peek("race_pre", KCTRL, 32'd1);
    KEY = 4'b1011; cyc(1);
    lw("race_lw_old", KDATA, 32'd6);
    peek("race_ctrl", KCTRL, 32'd1);
    peek("race_kdata", KDATA, 32'd4);

    // Misaligned address: not selected, no side effect.
    lw("misal_rd", KEYBASE_P1(), 32'd0);
    chk("misal_sel", {31'b0, bus_sel}, 32'd0);
    peek("misal_ctrl", KCTRL, 32'd1);

    // Event + store clearing ovr while ready: set wins.
    KEY = 4'b1111; cyc(3);
    peek("ovr_again", KCTRL, 32'd5);
    KEY = 4'b1110; cyc(1);
    sw_op(KCTRL, 32'd1);
    peek("set_wins", KCTRL, 32'd5);
    sw_op(KCTRL, 32'd0);

    // SW bounce then hold, with sie set.
    sw_op(SCTRL, 32'h10);
    peek("sie_wr", SCTRL, 32'h10);
    for (int i = 0; i < 5; i++) begin
      SW[0] = ~SW[0];
      if (i < 4) cyc(100);
    end
    peek("bounce_hold", SDATA, 32'd0);
    cyc(2 + DEB - 1);
    peek("deb_before", SDATA, 32'd0);
    chk("deb_irq0", {31'b0, irq}, 32'd0);
    cyc(1);
    peek("deb_after", SDATA, 32'd1);
    peek("deb_sctrl", SCTRL, 32'h11);
    chk("irq_lag", {31'b0, irq}, 32'd0);
    cyc(1);
    chk("irq_rise", {31'b0, irq}, 32'd1);
    lw("sw_lw", SDATA, 32'd1);
    peek("sw_rdclr", SCTRL, 32'h10);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    cyc(1);
    chk("irq_fall", {31'b0, irq}, 32'd0);

    // Async reset mid-debounce discards count and status.
    SW = 10'h003;
    cyc(500);
    #2 reset = 1'b1;
    #1 chk("rst_async_irq", {31'b0, irq}, 32'd0);
    peek("rst_mid_sdata", SDATA, 32'd0);
    peek("rst_mid_sctrl", SCTRL, 32'd0);
    peek("rst_mid_kctrl", KCTRL, 32'd0);
    cyc(2);
    reset = 1'b0;
    cyc(990);
    peek("post_rst_hold", SDATA, 32'd0);
    cyc(15);
    peek("post_rst_deb", SDATA, 32'd3);
    peek("post_rst_sctrl", SCTRL, 32'd1);
    chk("post_rst_irq", {31'b0, irq}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  function automatic logic [31:0] KEYBASE_P1();
    logic [31:0] a;
    a = KDATA + 32'd1;
    return a;
  endfunction
endmodule
